// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI-Stream width and lane-mask helpers
package axis_pkg;

    // Counter width for a lane index 0..ratio-1, never narrower than one bit.
    function automatic int cnt_width(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

    // One bit of the "lanes 0..last_lane set" keep mask.
    function automatic logic lane_mask_bit(input int lane, input int last_lane);
        return (lane <= last_lane);
    endfunction

endpackage

// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - packs RATIO narrow AXI-Stream beats into one wide beat
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    output logic [DATA_WIDTH*RATIO-1:0]   m_tdata,
    output logic [RATIO-1:0]              m_tkeep,
    output logic                          m_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready
);

    localparam int CW = cnt_width(RATIO);
    localparam int WW = DATA_WIDTH * RATIO;

    generate
        if (RATIO < 2) begin : g_bad_ratio
            $error("axis_upsizer: RATIO must be >= 2");
        end
    endgenerate

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    acc_q, acc_d;
    logic [WW-1:0]    m_tdata_q, m_tdata_d;
    logic [RATIO-1:0] m_tkeep_q, m_tkeep_d;
    logic             m_tlast_q, m_tlast_d;
    logic             m_tvalid_q, m_tvalid_d;

    logic             accept;
    logic             complete;
    logic [WW-1:0]    merged;
    logic [RATIO-1:0] keep_new;

    // Input is taken only when the output register is empty or draining this cycle.
    assign s_tready = rst && (!m_tvalid_q || m_tready);
    assign accept   = s_tvalid && s_tready;

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;

    // Next state: merge the current beat into lane cnt, emit on full word or tlast.
    always_comb begin
        merged   = acc_q;
        keep_new = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CW'(i) == cnt_q) begin
                merged[i*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
            end
            keep_new[i] = lane_mask_bit(i, int'(cnt_q));
        end
        complete = accept && ((cnt_q == CW'(RATIO - 1)) || s_tlast);

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (complete) begin
            // Accumulator is cleared after every word, so unfilled lanes are already 0.
            m_tvalid_d = 1'b1;
            m_tdata_d  = merged;
            m_tkeep_d  = keep_new;
            m_tlast_d  = s_tlast;
            cnt_d      = '0;
            acc_d      = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = merged;
        end
    end

    // State registers; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - directed self-checking bench for axis_upsizer
module tb_axis_upsizer;

    logic        clk;
    logic        rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;

    int checks = 0;
    int errors = 0;

    axis_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        tick();
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
    endtask

    logic [7:0]  bytes_q [64];
    logic [31:0] exp_word;
    int          beats;

    initial begin
        rst      = 1'b0;
        s_tdata  = 8'h55;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // T1 reset held with traffic present
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_s_tready", s_tready, 0);
            chk("t1_m_tvalid", m_tvalid, 0);
            chk("t1_m_tdata", m_tdata, 0);
            chk("t1_m_tkeep", m_tkeep, 0);
        end
        s_tvalid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("t1_s_tready_after_release", s_tready, 1);

        // T2 full word
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("t2_no_early_valid", m_tvalid, 0);
        send(8'h44, 1'b0);
        chk("t2_m_tvalid", m_tvalid, 1);
        chk("t2_m_tdata", m_tdata, 32'h44332211);
        chk("t2_m_tkeep", m_tkeep, 4'hF);
        chk("t2_m_tlast", m_tlast, 0);
        idle();
        chk("t2_valid_falls", m_tvalid, 0);

        // T3 short packet, then single-lane packet reloading while output drains
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        chk("t3_m_tvalid", m_tvalid, 1);
        chk("t3_m_tdata", m_tdata, 32'h0000B2A1);
        chk("t3_m_tkeep", m_tkeep, 4'h3);
        chk("t3_m_tlast", m_tlast, 1);
        send(8'hC3, 1'b1);
        chk("t3_lane0_valid_stays", m_tvalid, 1);
        chk("t3_lane0_m_tdata", m_tdata, 32'h000000C3);
        chk("t3_lane0_m_tkeep", m_tkeep, 4'h1);
        chk("t3_lane0_m_tlast", m_tlast, 1);
        idle();
        chk("t3_valid_falls", m_tvalid, 0);

        // T4 backpressure
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("t4_word1", m_tdata, 32'h04030201);
        m_tready = 1'b0;
        s_tdata  = 8'h05;
        s_tvalid = 1'b1;
        #1;
        chk("t4_s_tready_stalled", s_tready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_s_tready", s_tready, 0);
            chk("t4_stall_m_tvalid", m_tvalid, 1);
            chk("t4_stall_m_tdata", m_tdata, 32'h04030201);
        end
        m_tready = 1'b1;
        #1;
        chk("t4_s_tready_released", s_tready, 1);
        tick();
        chk("t4_drain_valid_falls", m_tvalid, 0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        chk("t4_word2_valid", m_tvalid, 1);
        chk("t4_word2", m_tdata, 32'h08070605);
        chk("t4_word2_keep", m_tkeep, 4'hF);

        // tlast on the final lane: full word with tlast
        send(8'h09, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b1);
        chk("tlast_lane3_data", m_tdata, 32'h0C0B0A09);
        chk("tlast_lane3_keep", m_tkeep, 4'hF);
        chk("tlast_lane3_last", m_tlast, 1);
        idle();

        // T5 streaming with scoreboard
        for (int i = 0; i < 64; i++) bytes_q[i] = 8'($urandom_range(0, 255));
        beats = 0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s_tdata = bytes_q[i];
            tick();
            if (m_tvalid) begin
                exp_word = {bytes_q[beats*4+3], bytes_q[beats*4+2],
                            bytes_q[beats*4+1], bytes_q[beats*4]};
                chk("t5_beat_cycle", i % 4, 3);
                chk("t5_beat_data", m_tdata, exp_word);
                chk("t5_beat_keep", m_tkeep, 4'hF);
                if (beats < 15) beats++;
                else beats = 16;
            end
        end
        chk("t5_beat_count", beats, 16);
        idle();
        chk("t5_idle_after", m_tvalid, 0);

        // T6 reset mid-word
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        s_tvalid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("t6_s_tready_in_reset", s_tready, 0);
        tick();
        rst = 1'b1;
        chk("t6_no_output_after_reset", m_tvalid, 0);
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        send(8'hE3, 1'b0);
        chk("t6_no_stale_word", m_tvalid, 0);
        send(8'hE4, 1'b0);
        chk("t6_valid", m_tvalid, 1);
        chk("t6_data", m_tdata, 32'hE4E3E2E1);
        chk("t6_keep", m_tkeep, 4'hF);
        idle();
        idle();
        chk("t6_single_output", m_tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
